// File: rtl/memory_if.sv
// AXI-stream beat handshake used between pipeline stages.
interface axis #(
  parameter int unsigned W = 32
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/memory.sv
// RV32 memory-access stage: forwards ALU results, performs loads/stores over a
// request/response data port and emits writeback beats.
package rv32;
  localparam int unsigned XLEN = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] funct3;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } rd_t;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rs2;
    rd_t             rd;
  } ex_data_t;

  typedef struct packed {
    ctrl_t    ctrl;
    ex_data_t data;
  } ex_t;

  typedef struct packed {
    rd_t rd;
  } wb_data_t;

  typedef struct packed {
    ctrl_t    ctrl;
    wb_data_t data;
  } wb_t;
endpackage

module memory #(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  axis.slave          source,
  axis.master         sink,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [3:0]  dmem_req_strb,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        fault
);
  localparam int unsigned XLEN   = rv32::XLEN;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned CNT_W  = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  rv32::ctrl_t         ctrl_q, ctrl_d;
  logic [4:0]          rd_addr_q, rd_addr_d;
  logic [1:0]          lane_q, lane_d;
  logic                req_valid_d, req_we_d;
  logic [XLEN-1:0]     req_addr_d, req_wdata_d;
  logic [STRB_W-1:0]   req_strb_d;
  logic                sink_valid_q, sink_valid_d;
  rv32::wb_t           wb_q, wb_d, wb_new_c;
  logic                fault_d, load_out_c;

  rv32::ex_t           ex_c;
  logic                out_free_c, src_hs_c, is_mem_c, is_store_c, misaligned_c;
  logic [STRB_W-1:0]   strb_c;
  logic [XLEN-1:0]     wdata_c, rsp_shift_c, load_data_c;
  logic                unused_c;

  assign ex_c          = rv32::ex_t'(source.tdata);
  assign out_free_c    = !sink_valid_q || sink.tready;
  assign source.tready = (state_q == IDLE) && out_free_c;
  assign src_hs_c      = source.tvalid && source.tready;
  assign sink.tvalid   = sink_valid_q;
  assign sink.tdata    = wb_q;
  assign unused_c      = ^ex_c.data.rd.data;

  // Op classification, byte lanes for stores and load alignment/extension.
  always_comb begin
    is_store_c   = (ex_c.ctrl.op == rv32::OP_STORE);
    is_mem_c     = (ex_c.ctrl.op == rv32::OP_LOAD) || is_store_c;
    misaligned_c = ex_c.ctrl.funct3[1] ? (|ex_c.data.alu[1:0])
                                       : (ex_c.ctrl.funct3[0] & ex_c.data.alu[0]);
    strb_c  = 4'b1111;
    wdata_c = ex_c.data.rs2;
    case (ex_c.ctrl.funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << ex_c.data.alu[1:0];
        wdata_c = {4{ex_c.data.rs2[7:0]}};
      end
      2'b01: begin
        strb_c  = 4'b0011 << ex_c.data.alu[1:0];
        wdata_c = {2{ex_c.data.rs2[15:0]}};
      end
      default: ;
    endcase

    rsp_shift_c = dmem_rsp_data >> {lane_q, 3'b000};
    load_data_c = rsp_shift_c;
    case (ctrl_q.funct3)
      3'b000:  load_data_c = {{24{rsp_shift_c[7]}}, rsp_shift_c[7:0]};
      3'b001:  load_data_c = {{16{rsp_shift_c[15]}}, rsp_shift_c[15:0]};
      3'b100:  load_data_c = {24'h0, rsp_shift_c[7:0]};
      3'b101:  load_data_c = {16'h0, rsp_shift_c[15:0]};
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    rd_addr_d    = rd_addr_q;
    lane_d       = lane_q;
    req_valid_d  = dmem_req_valid;
    req_we_d     = dmem_req_we;
    req_addr_d   = dmem_req_addr;
    req_strb_d   = dmem_req_strb;
    req_wdata_d  = dmem_req_wdata;
    fault_d      = 1'b0;
    load_out_c   = 1'b0;
    wb_new_c     = '0;

    case (state_q)
      IDLE: begin
        if (src_hs_c) begin
          if (!is_mem_c) begin
            load_out_c            = 1'b1;
            wb_new_c.ctrl         = ex_c.ctrl;
            wb_new_c.data.rd.addr = ex_c.data.rd.addr;
            wb_new_c.data.rd.data = ex_c.data.alu;
          end else if (misaligned_c) begin
            fault_d = 1'b1;
          end else begin
            state_d     = REQ;
            ctrl_d      = ex_c.ctrl;
            rd_addr_d   = ex_c.data.rd.addr;
            lane_d      = ex_c.data.alu[1:0];
            req_valid_d = 1'b1;
            req_we_d    = is_store_c;
            req_addr_d  = {ex_c.data.alu[XLEN-1:2], 2'b00};
            req_strb_d  = is_store_c ? strb_c : '0;
            req_wdata_d = wdata_c;
          end
        end
      end
      // REQ is only entered from IDLE after a handshake, so the output register is free.
      REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          if (dmem_req_we) begin
            load_out_c            = 1'b1;
            wb_new_c.ctrl         = ctrl_q;
            wb_new_c.data.rd.addr = rd_addr_q;
            state_d               = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rsp_valid) begin
          if (out_free_c) begin
            load_out_c            = 1'b1;
            wb_new_c.ctrl         = ctrl_q;
            wb_new_c.data.rd.addr = rd_addr_q;
            wb_new_c.data.rd.data = load_data_c;
            state_d               = IDLE;
          end
        end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_W'(RSP_TIMEOUT - 1))) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sink_valid_d = load_out_c ? 1'b1 : (sink.tready ? 1'b0 : sink_valid_q);
    wb_d         = load_out_c ? wb_new_c : wb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ctrl_q         <= '0;
      rd_addr_q      <= '0;
      lane_q         <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_strb  <= '0;
      dmem_req_wdata <= '0;
      sink_valid_q   <= 1'b0;
      wb_q           <= '0;
      fault          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ctrl_q         <= ctrl_d;
      rd_addr_q      <= rd_addr_d;
      lane_q         <= lane_d;
      dmem_req_valid <= req_valid_d;
      dmem_req_we    <= req_we_d;
      dmem_req_addr  <= req_addr_d;
      dmem_req_strb  <= req_strb_d;
      dmem_req_wdata <= req_wdata_d;
      sink_valid_q   <= sink_valid_d;
      wb_q           <= wb_d;
      fault          <= fault_d;
    end
  end
endmodule
